sd_emmc_dma_mem_reader: RTL and testbench

SD_EMMC_DMA_MEM_READER -- requirements
Module: sd_emmc_dma_mem_reader

---
 rtl/sd_emmc_dma_pkg.sv | 32 +++
 rtl/sd_emmc_dma_mem_reader_if.sv | 26 ++
 rtl/sd_emmc_dma_mem_reader.sv | 168 ++++++++++++++++
 tb/tb_sd_emmc_dma_mem_reader.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_emmc_dma_pkg.sv
// Shared types for the SD/eMMC SDMA memory reader: FSM encoding, block size
// and the buffer-boundary decode.
package sd_emmc_dma_pkg;

    localparam logic [7:0] WORDS_PER_BLK = 8'd128;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BLK_CHECK,
        NEW_SYS_ADDR,
        DONE
    } dma_state_t;

    // Boundary code n means a 2^(n+12)-byte window, i.e. 8 << n blocks of 512 bytes.
    function automatic logic [15:0] boundary_blocks(input logic [2:0] code);
        logic [15:0] blocks;
        case (code)
            3'd0:    blocks = 16'd8;
            3'd1:    blocks = 16'd16;
            3'd2:    blocks = 16'd32;
            3'd3:    blocks = 16'd64;
            3'd4:    blocks = 16'd128;
            3'd5:    blocks = 16'd256;
            3'd6:    blocks = 16'd512;
            default: blocks = 16'd1024;
        endcase
        return blocks;
    endfunction

endpackage

// File: rtl/sd_emmc_dma_mem_reader_if.sv
// Bus bundle for the SDMA reader: AXI read address/data channels plus the
// card-side TX FIFO push port.
interface sd_emmc_dma_mem_reader_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] fifo_wr_data;
    logic        fifo_wr_en;
    logic        fifo_full;

    modport master (
        output araddr, arvalid, rready, fifo_wr_data, fifo_wr_en,
        input  arready, rdata, rresp, rvalid, fifo_full
    );

    modport slave (
        input  araddr, arvalid, rready, fifo_wr_data, fifo_wr_en,
        output arready, rdata, rresp, rvalid, fifo_full
    );

endinterface

// File: rtl/sd_emmc_dma_mem_reader.sv
// SDMA memory-to-card reader: fetches 512-byte blocks word by word over AXI and
// pushes them into the card TX FIFO. Define SD_DMA_RRESP_CHECK_EN to act on rresp errors.
module sd_emmc_dma_mem_reader
    import sd_emmc_dma_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] init_dma_sys_addr,
    input  logic [15:0] block_count,
    input  logic [2:0]  buf_boundary,
    input  logic        sys_addr_changed,
    input  logic        dma_ena,
    input  logic        dir,
    input  logic        blk_count_ena,
    input  logic        xfer_start,
    input  logic        int_rst,
    sd_emmc_dma_mem_reader_if.master bus,
    output logic        dma_int,
    output logic        xfer_done,
    output logic        err_int
);

    dma_state_t  state;
    logic [31:0] araddr_q;
    logic        arvalid_q;
    logic        rready_q;
    logic [31:0] fifo_wr_data_q;
    logic        fifo_wr_en_q;
    logic        dma_int_q;
    logic        xfer_done_q;
    logic [7:0]  words_in_blk;
    logic [15:0] total_blk;
    logic [15:0] bound_blk;
    logic [15:0] blk_bound;
    logic [7:0]  words_next;
    logic        blk_complete;

    assign blk_bound    = boundary_blocks(buf_boundary);
    assign words_next   = words_in_blk + 8'd1;
    assign blk_complete = (words_next == WORDS_PER_BLK);

`ifdef SD_DMA_RRESP_CHECK_EN
    logic err_int_q;
    assign err_int = err_int_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^bus.rresp;
    assign err_int      = 1'b0;
`endif

    // Only one read is ever in flight and arvalid is raised only with FIFO room,
    // so every returned beat is guaranteed a free FIFO slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            araddr_q       <= '0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            fifo_wr_data_q <= '0;
            fifo_wr_en_q   <= 1'b0;
            dma_int_q      <= 1'b0;
            xfer_done_q    <= 1'b0;
            words_in_blk   <= '0;
            total_blk      <= '0;
            bound_blk      <= '0;
`ifdef SD_DMA_RRESP_CHECK_EN
            err_int_q      <= 1'b0;
`endif
        end else begin
            fifo_wr_en_q <= 1'b0;
            if (int_rst) begin
                dma_int_q   <= 1'b0;
                xfer_done_q <= 1'b0;
`ifdef SD_DMA_RRESP_CHECK_EN
                err_int_q   <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (dma_ena && !dir && xfer_start) begin
                        araddr_q     <= init_dma_sys_addr;
                        words_in_blk <= '0;
                        total_blk    <= '0;
                        bound_blk    <= '0;
                        state        <= ADDR;
                    end
                end
                ADDR: begin
                    if (arvalid_q && bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= DATA;
                    end else if (!xfer_start) begin
                        arvalid_q <= 1'b0;
                        state     <= IDLE;
                    end else if (!bus.fifo_full) begin
                        arvalid_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (bus.rvalid) begin
                        rready_q <= 1'b0;
`ifdef SD_DMA_RRESP_CHECK_EN
                        if (bus.rresp != 2'b00) begin
                            err_int_q <= 1'b1;
                            state     <= DONE;
                        end else
`endif
                        begin
                            fifo_wr_data_q <= bus.rdata;
                            fifo_wr_en_q   <= 1'b1;
                            araddr_q       <= araddr_q + 32'd4;
                            if (blk_complete) begin
                                words_in_blk <= '0;
                                total_blk    <= total_blk + 16'd1;
                                bound_blk    <= bound_blk + 16'd1;
                            end else begin
                                words_in_blk <= words_next;
                            end
                            if (!xfer_start)
                                state <= IDLE;
                            else if (blk_complete)
                                state <= BLK_CHECK;
                            else
                                state <= ADDR;
                        end
                    end
                end
                BLK_CHECK: begin
                    if (!xfer_start) begin
                        state <= IDLE;
                    end else if (blk_count_ena && (total_blk == block_count)) begin
                        xfer_done_q <= 1'b1;
                        state       <= DONE;
                    end else if (bound_blk == blk_bound) begin
                        dma_int_q <= 1'b1;
                        state     <= NEW_SYS_ADDR;
                    end else begin
                        state <= ADDR;
                    end
                end
                NEW_SYS_ADDR: begin
                    if (!xfer_start) begin
                        state <= IDLE;
                    end else if (sys_addr_changed) begin
                        araddr_q  <= init_dma_sys_addr;
                        bound_blk <= '0;
                        state     <= ADDR;
                    end
                end
                DONE: begin
                    if (!xfer_start)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.araddr       = araddr_q;
    assign bus.arvalid      = arvalid_q;
    assign bus.rready       = rready_q;
    assign bus.fifo_wr_data = fifo_wr_data_q;
    assign bus.fifo_wr_en   = fifo_wr_en_q;
    assign dma_int          = dma_int_q;
    assign xfer_done        = xfer_done_q;

endmodule

// File: tb/tb_sd_emmc_dma_mem_reader.sv
// Scoreboard bench for sd_emmc_dma_mem_reader: a delayed AXI memory model feeds the
// reader and every address and FIFO word is checked against queued expectations.
module tb_sd_emmc_dma_mem_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] init_dma_sys_addr;
    logic [15:0] block_count;
    logic [2:0]  buf_boundary;
    logic        sys_addr_changed;
    logic        dma_ena;
    logic        dir;
    logic        blk_count_ena;
    logic        xfer_start;
    logic        int_rst;
    logic        dma_int;
    logic        xfer_done;
    logic        err_int;

    sd_emmc_dma_mem_reader_if bus ();

    sd_emmc_dma_mem_reader dut (
        .clock             (clock),
        .reset             (reset),
        .init_dma_sys_addr (init_dma_sys_addr),
        .block_count       (block_count),
        .buf_boundary      (buf_boundary),
        .sys_addr_changed  (sys_addr_changed),
        .dma_ena           (dma_ena),
        .dir               (dir),
        .blk_count_ena     (blk_count_ena),
        .xfer_start        (xfer_start),
        .int_rst           (int_rst),
        .bus               (bus),
        .dma_int           (dma_int),
        .xfer_done         (xfer_done),
        .err_int           (err_int)
    );

    always #5 clock = ~clock;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          push_count = 0;
    int          ar_count = 0;
    int          arvalid_drops = 0;
    int          ar_delay = 0;
    int          r_delay = 0;
    logic [31:0] err_addr = '0;
    logic        err_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic queueWords(input logic [31:0] base, input int n);
        logic [31:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem_word(a));
            a = a + 32'd4;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [15:0] count,
                                 input logic ena, input logic [2:0] boundary);
        init_dma_sys_addr = base;
        block_count       = count;
        blk_count_ena     = ena;
        buf_boundary      = boundary;
        dma_ena           = 1'b1;
        dir               = 1'b0;
        push_count        = 0;
        ar_count          = 0;
        xfer_start        = 1'b1;
    endtask

    task automatic pulseIntRst();
        int_rst = 1'b1;
        tick();
        int_rst = 1'b0;
    endtask

    // which: 0 xfer_done, 1 dma_int, 2 rready, 3 err_int
    task automatic waitFlag(input int which, input int budget, input string tag);
        logic hit;
        logic flag;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (which)
                0:       flag = xfer_done;
                1:       flag = dma_int;
                2:       flag = bus.rready;
                default: flag = err_int;
            endcase
            if (flag) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        checkOutput(tag, 32'(hit), 32'd1);
    endtask

    task automatic waitPushes(input int n, input int budget, input string tag);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (seen < n && guard < budget) begin
            tick();
            guard++;
            if (bus.fifo_wr_en) seen++;
        end
        checkOutput(tag, seen, n);
    endtask

    task automatic checkResetOutputs(input string prefix);
        checkOutput({prefix, "_araddr"}, bus.araddr, 32'd0);
        checkOutput({prefix, "_arvalid"}, 32'(bus.arvalid), 32'd0);
        checkOutput({prefix, "_rready"}, 32'(bus.rready), 32'd0);
        checkOutput({prefix, "_fifo_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
        checkOutput({prefix, "_fifo_wr_data"}, bus.fifo_wr_data, 32'd0);
        checkOutput({prefix, "_dma_int"}, 32'(dma_int), 32'd0);
        checkOutput({prefix, "_xfer_done"}, 32'(xfer_done), 32'd0);
        checkOutput({prefix, "_err_int"}, 32'(err_int), 32'd0);
    endtask

    // AXI memory model: optional arready and rvalid latency, one beat per address.
    initial begin
        logic [31:0] cap;
        logic        acc;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        forever begin
            tick();
            if (!reset && bus.arvalid) begin
                for (int i = 0; i < ar_delay; i++) begin
                    tick();
                    if (!bus.arvalid) arvalid_drops++;
                end
                cap = bus.araddr;
                bus.arready = 1'b1;
                ar_count++;
                if (exp_addr_q.size() == 0)
                    checkOutput("ar_queue_empty", exp_addr_q.size(), 32'd1);
                else
                    checkOutput("araddr", cap, exp_addr_q.pop_front());
                tick();
                bus.arready = 1'b0;
                for (int i = 0; i < r_delay; i++) tick();
                bus.rdata  = mem_word(cap);
                bus.rresp  = (err_en && cap == err_addr) ? 2'b10 : 2'b00;
                bus.rvalid = 1'b1;
                for (int w = 0; w < 20; w++) begin
                    acc = bus.rready;
                    tick();
                    if (acc) break;
                end
                bus.rvalid = 1'b0;
                bus.rresp  = 2'b00;
            end
        end
    end

    // FIFO side scoreboard.
    initial begin
        forever begin
            tick();
            if (bus.fifo_wr_en) begin
                push_count++;
                if (exp_data_q.size() == 0)
                    checkOutput("push_queue_empty", exp_data_q.size(), 32'd1);
                else
                    checkOutput("fifo_wr_data", bus.fifo_wr_data, exp_data_q.pop_front());
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hits;
        int p0;
        reset             = 1'b1;
        init_dma_sys_addr = '0;
        block_count       = '0;
        buf_boundary      = '0;
        sys_addr_changed  = 1'b0;
        dma_ena           = 1'b0;
        dir               = 1'b0;
        blk_count_ena     = 1'b0;
        xfer_start        = 1'b0;
        int_rst           = 1'b0;
        bus.fifo_full     = 1'b0;
        repeat (3) tick();
        checkResetOutputs("reset");
        reset = 1'b0;
        tick();

        // dir=1 must leave the reader idle
        dir = 1'b1; dma_ena = 1'b1; xfer_start = 1'b1;
        hits = 0;
        repeat (10) begin tick(); if (bus.arvalid) hits++; end
        checkOutput("dir1_arvalid_count", hits, 0);
        xfer_start = 1'b0; dir = 1'b0;
        tick();

        // two blocks from 0x1000
        queueWords(32'h0000_1000, 256);
        applyStimulus(32'h0000_1000, 16'd2, 1'b1, 3'd7);
        waitFlag(0, 4000, "t1_xfer_done_seen");
        checkOutput("t1_pushes", push_count, 256);
        checkOutput("t1_ar_count", ar_count, 256);
        checkOutput("t1_data_left", exp_data_q.size(), 0);
        checkOutput("t1_addr_left", exp_addr_q.size(), 0);
        checkOutput("t1_dma_int", 32'(dma_int), 32'd0);
        xfer_start = 1'b0;
        repeat (3) tick();
        checkOutput("t1_done_sticky", 32'(xfer_done), 32'd1);
        checkOutput("t1_arvalid_idle", 32'(bus.arvalid), 32'd0);
        pulseIntRst();
        checkOutput("t1_int_rst_clears", 32'(xfer_done), 32'd0);

        // boundary 0: stall after block 8, resume at 0x8000
        queueWords(32'h0000_2000, 1024);
        queueWords(32'h0000_8000, 256);
        applyStimulus(32'h0000_2000, 16'd10, 1'b1, 3'd0);
        waitFlag(1, 8000, "t2_dma_int_seen");
        checkOutput("t2_pushes_at_bound", push_count, 1024);
        checkOutput("t2_xfer_done_early", 32'(xfer_done), 32'd0);
        hits = 0;
        repeat (20) begin tick(); if (bus.arvalid) hits++; end
        checkOutput("t2_stall_arvalid", hits, 0);
        checkOutput("t2_stall_pushes", push_count, 1024);
        init_dma_sys_addr = 32'h0000_8000;
        sys_addr_changed  = 1'b1;
        tick();
        sys_addr_changed  = 1'b0;
        waitFlag(0, 3000, "t2_xfer_done_seen");
        checkOutput("t2_pushes", push_count, 1280);
        checkOutput("t2_data_left", exp_data_q.size(), 0);
        checkOutput("t2_addr_left", exp_addr_q.size(), 0);
        checkOutput("t2_dma_int_sticky", 32'(dma_int), 32'd1);
        xfer_start = 1'b0;
        pulseIntRst();
        checkOutput("t2_dma_int_cleared", 32'(dma_int), 32'd0);

        // address wrap, slow slave, FIFO full back-pressure
        ar_delay = 5; r_delay = 3; arvalid_drops = 0;
        queueWords(32'hFFFF_FF00, 128);
        applyStimulus(32'hFFFF_FF00, 16'd1, 1'b1, 3'd1);
        waitPushes(10, 2000, "t3_first_pushes");
        bus.fifo_full = 1'b1;
        hits = 0;
        repeat (50) begin tick(); if (bus.arvalid) hits++; end
        checkOutput("t3_full_arvalid", hits, 0);
        checkOutput("t3_full_pushes", push_count, 10);
        bus.fifo_full = 1'b0;
        tick();
        checkOutput("t3_arvalid_after_release", 32'(bus.arvalid), 32'd1);
        waitFlag(0, 4000, "t3_xfer_done_seen");
        checkOutput("t3_pushes", push_count, 128);
        checkOutput("t3_data_left", exp_data_q.size(), 0);
        checkOutput("t3_addr_left", exp_addr_q.size(), 0);
        checkOutput("t3_arvalid_drops", arvalid_drops, 0);
        xfer_start = 1'b0;
        pulseIntRst();
        ar_delay = 0; r_delay = 0;

        // unbounded run, xfer_start dropped while a beat is outstanding
        r_delay = 2;
        queueWords(32'h0000_3000, 256);
        applyStimulus(32'h0000_3000, 16'd1, 1'b0, 3'd7);
        waitPushes(200, 3000, "t4_unbounded_pushes");
        waitFlag(2, 50, "t4_rready_seen");
        xfer_start = 1'b0;
        repeat (20) tick();
        checkOutput("t4_pushes_after_stop", push_count, 201);
        checkOutput("t4_arvalid", 32'(bus.arvalid), 32'd0);
        checkOutput("t4_rready", 32'(bus.rready), 32'd0);
        checkOutput("t4_xfer_done", 32'(xfer_done), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();

        // reset while waiting for data; the late beat must be ignored
        r_delay = 10;
        queueWords(32'h0000_4000, 8);
        applyStimulus(32'h0000_4000, 16'd1, 1'b1, 3'd7);
        waitFlag(2, 50, "t5_rready_seen");
        tick();
        tick();
        reset = 1'b1;
        xfer_start = 1'b0;
        tick();
        checkResetOutputs("t5");
        reset = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        p0 = push_count;
        repeat (40) tick();
        checkOutput("t5_late_rvalid_pushes", push_count, p0);
        checkOutput("t5_rready_idle", 32'(bus.rready), 32'd0);
        r_delay = 0;

        // error response on the fifth word
        err_en   = 1'b1;
        err_addr = 32'h0000_5010;
`ifdef SD_DMA_RRESP_CHECK_EN
        queueWords(32'h0000_5000, 4);
        exp_addr_q.push_back(32'h0000_5010);
        applyStimulus(32'h0000_5000, 16'd1, 1'b1, 3'd7);
        waitFlag(3, 500, "t6_err_int_seen");
        repeat (10) tick();
        checkOutput("t6_pushes", push_count, 4);
        checkOutput("t6_err_int", 32'(err_int), 32'd1);
        checkOutput("t6_xfer_done", 32'(xfer_done), 32'd0);
        checkOutput("t6_arvalid_done", 32'(bus.arvalid), 32'd0);
        checkOutput("t6_addr_left", exp_addr_q.size(), 0);
        xfer_start = 1'b0;
        pulseIntRst();
        checkOutput("t6_err_cleared", 32'(err_int), 32'd0);
`else
        queueWords(32'h0000_5000, 128);
        applyStimulus(32'h0000_5000, 16'd1, 1'b1, 3'd7);
        waitFlag(0, 1500, "t6_xfer_done_seen");
        checkOutput("t6_pushes", push_count, 128);
        checkOutput("t6_err_int", 32'(err_int), 32'd0);
        checkOutput("t6_data_left", exp_data_q.size(), 0);
        xfer_start = 1'b0;
        pulseIntRst();
`endif
        err_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
